// File: rtl/timer_pkg.sv
// Shared types and widths for the timer/PWM compare controller.
// Pure definitions; no logic, no latency, no flow control.
package timer_pkg;

  localparam int CNT_W        = 8;
  localparam int NUM_COMP_DEF = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [NUM_COMP_DEF-1:0][CNT_W-1:0] cmp_arr_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: tick is combinational from the registered count, one pulse per prescale+1 cycles.
// No backpressure; clear forces the count to 0 on the next edge and overrides run.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             pclk,
  input  logic             presetn,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] prescale,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == prescale);

  // A prescale lowered below the live count lets cnt wrap through 255 before it matches again.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Run/stop sequencer, prescaled counter, double-buffered compares and sticky flags for the PWM block.
// All outputs registered, one pclk after the causing event; no backpressure, pulses are consumed at once.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int NUM_COMP = 3
) (
  input  logic                               pclk,
  input  logic                               presetn,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               oneshot,
  input  logic [CNT_W-1:0]                   prescale,
  input  logic [CNT_W-1:0]                   period,
  input  logic [NUM_COMP-1:0][CNT_W-1:0]     match_value_in,
  input  logic                               upd_req,
  input  logic [NUM_COMP-1:0]                flag_clr,
  input  logic                               ovf_clr,
  output logic                               en,
  output logic [CNT_W-1:0]                   counter_value,
  output logic [NUM_COMP-1:0][CNT_W-1:0]     match_value,
  output logic [NUM_COMP-1:0]                flag,
  output logic                               ovf_flag,
  output logic                               upd_pending
);

  state_t                           state;
  logic [NUM_COMP-1:0][CNT_W-1:0]   shadow;
  logic [NUM_COMP-1:0]              hit;
  logic                             tick_raw;
  logic                             tick;
  logic                             wrap;
  logic                             go;
  logic                             apply;

  timer_prescaler u_prescaler (
    .pclk     (pclk),
    .presetn  (presetn),
    .run      (state == RUN),
    .clear    ((state != RUN) || stop),
    .prescale (prescale),
    .tick     (tick_raw)
  );

  // stop outranks everything on its cycle, including a coinciding tick
  assign tick  = tick_raw && !stop;
  assign wrap  = tick && (counter_value == period);
  assign go    = (state == IDLE) && start && !stop;
  assign apply = upd_pending && (go || wrap);
  assign en    = (state == RUN);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      hit[i] = tick && (counter_value == match_value[i]);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= IDLE;
      counter_value <= '0;
    end else if (state == IDLE) begin
      counter_value <= '0;
      if (go) state <= RUN;
    end else if (stop) begin
      state         <= IDLE;
      counter_value <= '0;
    end else if (wrap) begin
      counter_value <= '0;
      if (oneshot) state <= IDLE;
    end else if (tick) begin
      counter_value <= counter_value + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      flag     <= '0;
      ovf_flag <= 1'b0;
    end else begin
      flag     <= (flag & ~flag_clr) | hit;
      ovf_flag <= (ovf_flag & ~ovf_clr) | wrap;
    end
  end

  // An idle write goes straight to active and supersedes any shadow left behind by a stop.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      match_value <= '0;
      shadow      <= '0;
      upd_pending <= 1'b0;
    end else if ((state == IDLE) && upd_req) begin
      match_value <= match_value_in;
      upd_pending <= 1'b0;
    end else begin
      if (apply) begin
        match_value <= shadow;
      end
      if ((state == RUN) && upd_req) begin
        shadow      <= match_value_in;
        upd_pending <= 1'b1;
      end else if (apply) begin
        upd_pending <= 1'b0;
      end
    end
  end

endmodule
